order_content_ctrl: RTL

//  Front-end controller sitting directly upstream of the 4096x217 order-content block RAM.

---
 rtl/order_content_pkg.sv | 13 +
 rtl/order_rsp_fifo.sv | 55 +++++
 rtl/order_content_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/order_content_pkg.sv
// rtl/order_content_pkg.sv - shared constants and types for the order-content RAM front end
package order_content_pkg;

  localparam int DATA_W     = 217;
  localparam int ADDR_W     = 12;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int STARVE_LIM = 4;
  localparam int RSP_DEPTH  = 4;

  typedef logic [DATA_W-1:0] order_rec_t;
  typedef logic [ADDR_W-1:0] slot_idx_t;

endpackage

// File: rtl/order_rsp_fifo.sv
// rtl/order_rsp_fifo.sv - small synchronous FIFO holding fetch responses (data + slot index)
// Head output reads zero while empty so the response bus is quiet after reset.
module order_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & (r_count != FULL_CNT);
  assign w_pop  = pop & (r_count != '0);
  assign valid  = (r_count != '0);
  assign head   = valid ? r_mem[r_rd] : '0;
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/order_content_ctrl.sv
// rtl/order_content_ctrl.sv - store/fetch arbiter and single-port owner for the order-content RAM
// Optional ORDER_CTRL_STATS_EN adds store/fetch/full-stall counters.
module order_content_ctrl
  import order_content_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_idx_valid,
  output logic [ADDR_W-1:0] st_idx,
  input  logic              rel_valid,
  input  logic              fr_valid,
  output logic              fr_ready,
  input  logic [ADDR_W-1:0] fr_idx,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_idx,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef ORDER_CTRL_STATS_EN
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_fetches,
  output logic [31:0]       stat_full_stalls,
`endif
  output logic [ADDR_W:0]   occupancy
);

  localparam int CNT_W    = $clog2(RSP_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W:0]   FULL_OCC  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  RSP_LIM   = CNT_W'(RSP_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  logic [ADDR_W:0]     r_occ;
  logic [ADDR_W-1:0]   r_ptr;
  logic [STARVE_W-1:0] r_starve;
  logic                r_st_idx_valid;
  logic [ADDR_W-1:0]   r_st_idx;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_p1_valid;
  logic                r_p2_valid;
  logic [ADDR_W-1:0]   r_p1_idx;
  logic [ADDR_W-1:0]   r_p2_idx;

  logic [CNT_W-1:0]         w_fifo_count;
  logic [CNT_W-1:0]         w_pending;
  logic                     w_st_elig;
  logic                     w_fr_elig;
  logic                     w_starved;
  logic                     w_fr_ok;
  logic                     w_st_ok;
  logic                     w_fr_grant;
  logic                     w_st_grant;
  logic                     w_rel;
  logic [DATA_W+ADDR_W-1:0] w_head;

  // Responses already queued plus reads still in the RAM pipeline must fit in the FIFO.
  assign w_pending  = w_fifo_count + CNT_W'(r_p1_valid) + CNT_W'(r_p2_valid);
  assign w_st_elig  = (r_occ != FULL_OCC);
  assign w_fr_elig  = (w_pending < RSP_LIM);
  assign w_starved  = st_valid & w_st_elig & (r_starve == STARVE_MAX);
  assign w_fr_ok    = ~reset & w_fr_elig & ~w_starved;
  assign w_fr_grant = fr_valid & w_fr_ok;
  assign w_st_ok    = ~reset & w_st_elig & ~w_fr_grant;
  assign w_st_grant = st_valid & w_st_ok;
  assign w_rel      = rel_valid & (r_occ != '0);

  assign st_ready     = w_st_ok;
  assign fr_ready     = w_fr_ok;
  assign st_idx_valid = r_st_idx_valid;
  assign st_idx       = r_st_idx;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign occupancy    = r_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ          <= '0;
      r_ptr          <= '0;
      r_starve       <= '0;
      r_st_idx_valid <= 1'b0;
      r_st_idx       <= '0;
      r_ram_we       <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_din      <= '0;
      r_p1_valid     <= 1'b0;
      r_p2_valid     <= 1'b0;
      r_p1_idx       <= '0;
      r_p2_idx       <= '0;
    end else begin
      r_st_idx_valid <= w_st_grant;
      r_ram_we       <= w_st_grant;
      if (w_st_grant) begin
        r_ram_addr <= r_ptr;
        r_ram_din  <= st_data;
        r_st_idx   <= r_ptr;
        r_ptr      <= r_ptr + 1'b1;
      end else if (w_fr_grant) begin
        r_ram_addr <= fr_idx;
      end

      case ({w_st_grant, w_rel})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      if (w_st_grant || !st_valid) begin
        r_starve <= '0;
      end else if (w_fr_grant && w_st_elig) begin
        r_starve <= r_starve + 1'b1;
      end

      r_p1_valid <= w_fr_grant;
      r_p1_idx   <= fr_idx;
      r_p2_valid <= r_p1_valid;
      r_p2_idx   <= r_p1_idx;
    end
  end

  order_rsp_fifo #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_p2_valid),
    .push_data ({ram_dout, r_p2_idx}),
    .pop       (rsp_valid & rsp_ready),
    .valid     (rsp_valid),
    .head      (w_head),
    .count     (w_fifo_count)
  );

  assign rsp_data = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign rsp_idx  = w_head[ADDR_W-1:0];

`ifdef ORDER_CTRL_STATS_EN
  logic [31:0] r_stat_stores;
  logic [31:0] r_stat_fetches;
  logic [31:0] r_stat_full_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_stores      <= '0;
      r_stat_fetches     <= '0;
      r_stat_full_stalls <= '0;
    end else begin
      r_stat_stores      <= r_stat_stores + 32'(w_st_grant);
      r_stat_fetches     <= r_stat_fetches + 32'(w_fr_grant);
      r_stat_full_stalls <= r_stat_full_stalls + 32'(st_valid & (r_occ == FULL_OCC));
    end
  end

  assign stat_stores      = r_stat_stores;
  assign stat_fetches     = r_stat_fetches;
  assign stat_full_stalls = r_stat_full_stalls;
`endif

endmodule
